// File: rtl/spi_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// spi_bus_arbiter_if
//   Bundles the requester side and the SPI-master side of spi_bus_arbiter.
//   Parameters NUM_REQ and DW must match the arbiter instance.
//
//   Requester side : req, lock, wdata (in to arbiter)
//                    gnt, done, rdata, err (out of arbiter)
//   SPI master side: m_data_o, m_send, m_cs (out of arbiter)
//                    m_ready, m_data_i (in to arbiter)
//
//   modport master : the arbiter's view (it masters the shared SPI engine)
//   modport slave  : the environment's view (requesters plus SPI engine)
// -----------------------------------------------------------------------------
interface spi_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 32
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    lock;
  logic [NUM_REQ*DW-1:0] wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic [DW-1:0]         rdata;
  logic                  err;
  logic [DW-1:0]         m_data_o;
  logic                  m_send;
  logic [NUM_REQ-1:0]    m_cs;
  logic                  m_ready;
  logic [DW-1:0]         m_data_i;

  modport master (
    input  req, lock, wdata, m_ready, m_data_i,
    output gnt, done, rdata, err, m_data_o, m_send, m_cs
  );

  modport slave (
    output req, lock, wdata, m_ready, m_data_i,
    input  gnt, done, rdata, err, m_data_o, m_send, m_cs
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// spi_bus_arbiter
//   Shares one SPI master between NUM_REQ requesters. Word transfers are
//   granted round-robin; a requester holding lock keeps the grant (and CS)
//   across a multi-word burst. Read data and a one-cycle done pulse are
//   returned to the owner when its word completes.
//
//   Ports
//     clk  : system clock, all logic on posedge
//     rst  : asynchronous reset, active-high
//     bus  : spi_bus_arbiter_if.master
//            req/lock/wdata in, gnt/done/rdata/err out  (requesters)
//            m_data_o/m_send/m_cs out, m_ready/m_data_i in (SPI master)
//
//   Build option
//     SPI_ARB_TIMEOUT_EN : when defined, a watchdog aborts a transfer that
//     spends TIMEOUT cycles in WAIT_BUSY or WAIT_DONE, setting sticky err.
//     When undefined no counter exists, err is 0 and the FSM waits forever.
// -----------------------------------------------------------------------------
module spi_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DW         = 32,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  spi_bus_arbiter_if.master   bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    SEND,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d;         // last owner; also the current owner while granted
  logic [NUM_REQ-1:0] gnt_q, gnt_d;       // drives both gnt and m_cs
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic [DW-1:0]      data_o_q, data_o_d;
  logic               send_q, send_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               wd_expire;

  // Per-requester write words, unpacked for indexed selection.
  logic [DW-1:0] wdata_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_wdata
      assign wdata_arr[gi] = bus.wdata[gi*DW +: DW];
    end
  endgenerate

  // Round-robin pick: first asserted request scanning from rr+1 with wrap.
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand_idx;
  int            cand;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = rr_q;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(rr_q) + k) % NUM_REQ;
      cand_idx = IW'(cand);
      if (!pick_valid && bus.req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    rdata_d  = rdata_q;
    data_o_d = data_o_q;
    gap_d    = gap_q;
    // m_send is the SEND state delayed by one register, so the strobe rises
    // the cycle after SEND and lasts exactly one cycle.
    send_d   = (state_q == SEND);

    case (state_q)
      IDLE: begin
        if ((|bus.req) && bus.m_ready) begin
          state_d = ARB;
        end
      end

      ARB: begin
        if (pick_valid) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          data_o_d        = wdata_arr[pick_idx];
          rr_d            = pick_idx;
          state_d         = SEND;
        end else begin
          // Request withdrawn between IDLE and ARB: no grant is issued.
          state_d = IDLE;
        end
      end

      SEND: begin
        state_d = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        if (!bus.m_ready) begin
          state_d = WAIT_DONE;
        end else if (wd_expire) begin
          gnt_d   = '0;
          done_d  = gnt_q;
          gap_d   = GW'(GAP_CYCLES);
          state_d = GAP;
        end
      end

      WAIT_DONE: begin
        if (bus.m_ready) begin
          rdata_d = bus.m_data_i;
          done_d  = gnt_q;
          // Burst continues only while the owner still both requests and locks.
          if (bus.lock[rr_q] && bus.req[rr_q]) begin
            data_o_d = wdata_arr[rr_q];
            state_d  = SEND;
          end else begin
            gnt_d   = '0;
            gap_d   = GW'(GAP_CYCLES);
            state_d = GAP;
          end
        end else if (wd_expire) begin
          // Watchdog abort: owner still gets done, rdata is left untouched.
          gnt_d   = '0;
          done_d  = gnt_q;
          gap_d   = GW'(GAP_CYCLES);
          state_d = GAP;
        end
      end

      GAP: begin
        if (gap_q <= GW'(1)) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= IW'(NUM_REQ - 1);
      gnt_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      data_o_q <= '0;
      send_q   <= 1'b0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      data_o_q <= data_o_d;
      send_q   <= send_d;
      gap_q    <= gap_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WDW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  logic           in_wait;

  assign in_wait   = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  assign wd_expire = in_wait && (wd_q == WDW'(TIMEOUT - 1));

  always_comb begin
    // Counter restarts whenever a wait state is (re)entered.
    if (!in_wait || (state_d != state_q)) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + WDW'(1);
    end
    err_d = err_q;
    if (wd_expire &&
        (((state_q == WAIT_BUSY) && bus.m_ready) ||
         ((state_q == WAIT_DONE) && !bus.m_ready))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign wd_expire = 1'b0;
  assign bus.err   = 1'b0;
`endif

  assign bus.gnt      = gnt_q;
  assign bus.m_cs     = gnt_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.m_data_o = data_o_q;
  assign bus.m_send   = send_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_bus_arbiter
//   Directed bench for spi_bus_arbiter. A small SPI master model answers each
//   m_send with a reply word; a scoreboard queue holds the expected owner,
//   write word and read word of every transfer and is checked at m_send and
//   at done. Define SPI_ARB_TIMEOUT_EN to also exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_spi_bus_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DW         = 32;
  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 20;

  logic clk;
  logic rst;

  spi_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .DW(DW)) bus ();

  spi_bus_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DW         (DW),
    .GAP_CYCLES (GAP_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          owner;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] reply_q[$];
  logic [31:0] wd_val [NUM_REQ];
  logic [31:0] model_rdata;
  logic        exp_err;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- SPI master model ----------------
  int          master_lat;
  logic        hold_busy;
  int          busy_cnt;
  logic        m_send_prev;
  logic [31:0] cur_reply;

  always @(negedge clk) begin
    if (rst) begin
      bus.m_ready = 1'b1;
      busy_cnt    = 0;
      m_send_prev = 1'b0;
    end else begin
      if (bus.m_send && !m_send_prev) begin
        bus.m_ready = 1'b0;
        cur_reply   = (reply_q.size() > 0) ? reply_q.pop_front() : 32'h0;
        busy_cnt    = hold_busy ? -1 : master_lat;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          bus.m_data_i = cur_reply;
          bus.m_ready  = 1'b1;
        end
      end
      m_send_prev = bus.m_send;
    end
  end

  // ---------------- Monitor / scoreboard ----------------
  int               cyc = 0;
  int               done_count = 0;
  int               send_count = 0;
  int               cs_drops = 0;
  int               last_done_cyc = 0;
  int               last_send_cyc = 0;
  int               last_send_delta = 0;
  int               last_done_delta = 0;
  int               gap_run = 0;
  logic             had_xfer = 1'b0;
  logic             mon_send_prev = 1'b0;
  logic [NUM_REQ-1:0] prev_cs = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mon_send_prev = 1'b0;
      prev_cs       = '0;
      had_xfer      = 1'b0;
      gap_run       = 0;
    end else begin
      // Chip-select handover and idle gap between owners.
      if (bus.m_cs != prev_cs) begin
        if (prev_cs != '0) begin
          check("cs_handover", bus.m_cs, '0);
          cs_drops++;
        end else if (had_xfer) begin
          check("cs_gap", (gap_run >= GAP_CYCLES), 1'b1);
        end
      end
      if (bus.m_cs == '0) gap_run++;
      else begin
        gap_run  = 0;
        had_xfer = 1'b1;
      end
      prev_cs = bus.m_cs;

      if (bus.m_send && !mon_send_prev) begin
        send_count++;
        last_send_delta = cyc - last_done_cyc;
        last_send_cyc   = cyc;
        check("gnt_eq_cs", bus.gnt, bus.m_cs);
        if (exp_q.size() == 0) begin
          check("unexpected_send_cs", bus.m_cs, '0);
        end else begin
          check("send_cs", bus.m_cs, 4'b0001 << exp_q[0].owner);
          check("send_wdata", bus.m_data_o, exp_q[0].wdata);
        end
        $display("send  t=%0t cs=%b wdata=%h", $time, bus.m_cs, bus.m_data_o);
      end
      mon_send_prev = bus.m_send;

      if (bus.done != '0) begin
        exp_t e;
        last_done_delta = cyc - last_send_cyc;
        last_done_cyc   = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_done", bus.done, '0);
        end else begin
          e = exp_q.pop_front();
          check("done_owner", bus.done, 4'b0001 << e.owner);
          check("done_rdata", bus.rdata, e.rdata);
          check("done_err", bus.err, exp_err);
        end
        done_count++;
        $display("done  t=%0t done=%b rdata=%h err=%b", $time, bus.done, bus.rdata, bus.err);
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_xfer(input int owner, input logic [31:0] rd);
    exp_t e;
    e.owner = owner;
    e.wdata = wd_val[owner];
    e.rdata = rd;
    exp_q.push_back(e);
    reply_q.push_back(rd);
    model_rdata = rd;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (done_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, done_count, target);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    reply_q.delete();
    model_rdata = '0;
    exp_err     = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- Directed sequence ----------------
  initial begin
    int base;
    int c;
    int drops0;

    rst         = 1'b1;
    hold_busy   = 1'b0;
    master_lat  = 3;
    model_rdata = '0;
    exp_err     = 1'b0;
    bus.req     = '0;
    bus.lock    = '0;
    bus.m_data_i = '0;
    for (int i = 0; i < NUM_REQ; i++) wd_val[i] = 32'hA5A5_0000 | i;
    bus.wdata = {wd_val[3], wd_val[2], wd_val[1], wd_val[0]};

    // Reset state
    @(negedge clk);
    check("rst_gnt", bus.gnt, '0);
    check("rst_done", bus.done, '0);
    check("rst_rdata", bus.rdata, '0);
    check("rst_err", bus.err, 1'b0);
    check("rst_send", bus.m_send, 1'b0);
    check("rst_cs", bus.m_cs, '0);
    check("rst_data_o", bus.m_data_o, '0);
    tick(1);
    rst = 1'b0;
    tick(2);

    // 1. Single request from requester 1
    $display("test1 single request");
    base = done_count;
    expect_xfer(1, 32'h1234_5678);
    bus.req = 4'b0010;
    @(negedge clk);
    c = 0;
    while (!bus.m_send && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("t1_req_to_send", c, 3);
    check("t1_gnt", bus.gnt, 4'b0010);
    bus.req = '0;                       // word must still complete
    bus.wdata[1*DW +: DW] = 32'hDEAD_BEEF; // ignored mid-transfer
    wait_done(base + 1, 50, "t1_done_wait");
    check("t1_rdata_hold", bus.rdata, 32'h1234_5678);
    @(negedge clk);
    check("t1_gnt_cleared", bus.gnt, '0);
    bus.wdata = {wd_val[3], wd_val[2], wd_val[1], wd_val[0]};
    tick(6);

    // 2. Contention, all requesting after reset: order 0,1,2,3,0
    $display("test2 contention");
    apply_reset();
    base = done_count;
    expect_xfer(0, $urandom);
    expect_xfer(1, $urandom);
    expect_xfer(2, $urandom);
    expect_xfer(3, $urandom);
    expect_xfer(0, $urandom);
    bus.req = 4'b1111;
    wait_done(base + 5, 300, "t2_done_wait");
    bus.req = '0;
    tick(10);
    check("t2_queue_empty", exp_q.size(), 0);

    // 3. Locked burst of three words by requester 2 while 0 waits
    $display("test3 burst");
    base   = done_count;
    drops0 = cs_drops;
    expect_xfer(2, $urandom);
    expect_xfer(2, $urandom);
    expect_xfer(2, $urandom);
    expect_xfer(0, $urandom);
    bus.req  = 4'b0101;
    bus.lock = 4'b0100;
    wait_done(base + 2, 100, "t3_two_words");
    bus.lock = '0;
    wait_done(base + 3, 100, "t3_three_words");
    check("t3_cs_continuous", cs_drops - drops0, 1);
    check("t3_reload_latency", last_send_delta, 1);
    bus.req = 4'b0001;
    wait_done(base + 4, 100, "t3_then_owner0");
    bus.req = '0;
    tick(8);

    // 5. Request withdrawn after one cycle in IDLE
    $display("test5 withdrawn request");
    base = send_count;
    bus.req = 4'b1000;
    tick(1);
    bus.req = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_gnt", bus.gnt, '0);
    end
    check("t5_no_send", send_count, base);

    // 4. Reset during WAIT_DONE, then re-arbitration starts at requester 0
    $display("test4 reset mid-transfer");
    tick(1);
    master_lat = 12;
    base = send_count;
    expect_xfer(3, $urandom);
    bus.req = 4'b1000;
    c = 0;
    while (send_count == base && c < 30) begin
      @(negedge clk);
      c++;
    end
    check("t4_send_seen", send_count, base + 1);
    repeat (3) @(negedge clk);
    base = done_count;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t4_send_in_rst", bus.m_send, 1'b0);
    check("t4_cs_in_rst", bus.m_cs, '0);
    check("t4_gnt_in_rst", bus.gnt, '0);
    check("t4_done_in_rst", bus.done, '0);
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    reply_q.delete();
    model_rdata = '0;
    check("t4_no_done", done_count, base);
    master_lat = 3;
    expect_xfer(0, $urandom);
    bus.req = 4'b1001;
    wait_done(base + 1, 100, "t4_rearb_done");
    bus.req = '0;
    tick(8);

`ifdef SPI_ARB_TIMEOUT_EN
    // 6. Watchdog: master never finishes
    $display("test6 watchdog");
    begin
      exp_t e;
      e.owner = 1;
      e.wdata = wd_val[1];
      e.rdata = model_rdata;   // rdata must be left unchanged
      exp_q.push_back(e);
    end
    exp_err   = 1'b1;
    hold_busy = 1'b1;
    base      = done_count;
    bus.req   = 4'b0010;
    wait_done(base + 1, 100, "t6_abort_done");
    check("t6_abort_delay", last_done_delta, TIMEOUT + 1);
    check("t6_cs_dropped", bus.m_cs, '0);
    check("t6_err", bus.err, 1'b1);
    bus.req = '0;
    tick(10);
    check("t6_err_sticky", bus.err, 1'b1);
    hold_busy = 1'b0;
    apply_reset();
    @(negedge clk);
    check("t6_err_cleared", bus.err, 1'b0);
`else
    check("err_tied_low", bus.err, 1'b0);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
